sync_fifo: RTL and testbench

Single-clock, parameterised first-in/first-out buffer built from a register array with read/write pointers.
Used as a generic elastic buffer between a producer and a consumer in the same clock domain.
Read side is first-word-fall-through: the oldest entry is always presented on rd_data, and a read pops it.
Status flags full and empty provide the flow-control handshake.

---
 rtl/sync_fifo.sv | 35 +++
 tb/tb_sync_fifo.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FWFT FIFO with wrap-bit pointers and a zero-gated head output
module sync_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr,
  input  logic                  rd,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  empty,
  output logic                  full
);
  logic [DATA_WIDTH-1:0] r_mem [2**ADDR_WIDTH];
  logic [ADDR_WIDTH:0]   r_wr_ptr, r_rd_ptr;
  logic                  w_rd_acc, w_wr_acc;
  assign empty    = r_wr_ptr == r_rd_ptr;
  assign full     = (r_wr_ptr[ADDR_WIDTH-1:0] == r_rd_ptr[ADDR_WIDTH-1:0]) &&
                    (r_wr_ptr[ADDR_WIDTH] != r_rd_ptr[ADDR_WIDTH]);
  assign w_rd_acc = rd && !empty;
  // a read in the same cycle frees the slot, so a full FIFO still takes the write
  assign w_wr_acc = wr && (!full || w_rd_acc);
  assign rd_data  = empty ? '0 : r_mem[r_rd_ptr[ADDR_WIDTH-1:0]];
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_acc) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  always_ff @(posedge clk)
    if (w_wr_acc && reset) r_mem[r_wr_ptr[ADDR_WIDTH-1:0]] <= wr_data;
endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: scenario tasks checked against a queue model of a 16-deep FIFO
module tb_sync_fifo;
  localparam int DEPTH = 16;
  logic       clk = 0, reset = 0, wr = 0, rd = 0;
  logic [7:0] wr_data = 0, rd_data;
  logic       empty, full;
  logic [7:0] q[$];
  int         n_chk = 0, n_fail = 0;

  sync_fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
    .clk(clk), .reset(reset), .wr(wr), .rd(rd),
    .wr_data(wr_data), .rd_data(rd_data), .empty(empty), .full(full)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] exp_data();
    return q.size() > 0 ? q[0] : 8'h00;
  endfunction

  // one clock: apply inputs, advance the model by the FIFO acceptance rules
  task automatic cycle(input logic w, input logic r, input logic [7:0] d);
    bit rok, wok;
    rok = r && q.size() > 0;
    wok = w && (q.size() < DEPTH || rok);
    wr = w; rd = r; wr_data = d;
    @(posedge clk); #1;
    if (rok) q.delete(0);
    if (wok) q.push_back(d);
  endtask

  task automatic test_reset();
    reset = 0; wr = 0; rd = 0;
    repeat (2) @(posedge clk);
    #1;
    n_chk++;
    if (empty !== 1'b1 || full !== 1'b0 || rd_data !== 8'h00) begin
      n_fail++;
      $display("FAIL reset: empty=%b full=%b rd_data=%h, want 1 0 00", empty, full, rd_data);
    end
    #2 reset = 1;
    q.delete();
    cycle(0, 1, 8'h00);
    n_chk++;
    if (empty !== 1'b1 || rd_data !== 8'h00) begin
      n_fail++;
      $display("FAIL read_empty: empty=%b rd_data=%h, want 1 00", empty, rd_data);
    end
  endtask

  task automatic test_push_pop();
    logic [7:0] v[10] = '{8'h24, 8'h81, 8'h09, 8'h63, 8'h0D, 8'h8D, 8'h65, 8'h12, 8'h01, 8'h0D};
    for (int i = 0; i < 10; i++) begin
      cycle(1, 0, v[i]);
      n_chk++;
      if (rd_data !== 8'h24 || empty !== 1'b0 || full !== 1'b0) begin
        n_fail++;
        $display("FAIL push[%0d]: rd_data=%h empty=%b full=%b, want 24 0 0", i, rd_data, empty, full);
      end
    end
    for (int i = 0; i < 10; i++) begin
      n_chk++;
      if (rd_data !== v[i]) begin
        n_fail++;
        $display("FAIL pop[%0d]: rd_data=%h, want %h", i, rd_data, v[i]);
      end
      cycle(0, 1, 8'h00);
    end
    n_chk++;
    if (empty !== 1'b1 || rd_data !== 8'h00) begin
      n_fail++;
      $display("FAIL pop_empty: empty=%b rd_data=%h, want 1 00", empty, rd_data);
    end
    cycle(0, 0, 8'h00);
  endtask

  task automatic test_fill();
    logic [7:0] v[DEPTH];
    for (int i = 0; i < DEPTH; i++) begin
      v[i] = 8'($urandom_range(0, 254));
      n_chk++;
      if (full !== 1'b0) begin
        n_fail++;
        $display("FAIL fill_early_full[%0d]: full=%b, want 0", i, full);
      end
      cycle(1, 0, v[i]);
    end
    n_chk++;
    if (full !== 1'b1 || empty !== 1'b0) begin
      n_fail++;
      $display("FAIL fill_full: full=%b empty=%b, want 1 0", full, empty);
    end
    cycle(1, 0, 8'hFF);
    n_chk++;
    if (full !== 1'b1 || rd_data !== v[0] || q.size() != DEPTH) begin
      n_fail++;
      $display("FAIL fill_drop: full=%b rd_data=%h, want 1 %h", full, rd_data, v[0]);
    end
    for (int i = 0; i < DEPTH; i++) begin
      n_chk++;
      if (rd_data !== v[i]) begin
        n_fail++;
        $display("FAIL fill_pop[%0d]: rd_data=%h, want %h", i, rd_data, v[i]);
      end
      cycle(0, 1, 8'h00);
    end
    n_chk++;
    if (empty !== 1'b1 || full !== 1'b0 || rd_data !== 8'h00) begin
      n_fail++;
      $display("FAIL fill_drained: empty=%b full=%b rd_data=%h, want 1 0 00", empty, full, rd_data);
    end
  endtask

  task automatic test_interleave();
    for (int i = 0; i < 25; i++) begin
      cycle(i < 20, i >= 5, 8'($urandom));
      n_chk++;
      if (rd_data !== exp_data() || empty !== (q.size() == 0) || full !== 1'b0 ||
          (i >= 5 && i < 20 && q.size() != 5)) begin
        n_fail++;
        $display("FAIL interleave[%0d]: rd_data=%h empty=%b full=%b occ=%0d, want %h %b 0 5",
                 i, rd_data, empty, full, q.size(), exp_data(), q.size() == 0);
      end
    end
    while (q.size() > 0) cycle(0, 1, 8'h00);
  endtask

  task automatic test_wrap();
    int pushed = 0;
    logic [7:0] nxt;
    for (int i = 0; i < 12; i++) cycle(1, 0, 8'($urandom));
    while (pushed < 40) begin
      bit w, r;
      w = q.size() < DEPTH ? 1'b1 : 1'($urandom);
      r = q.size() > 8 ? 1'($urandom) : 1'b0;
      if (q.size() == DEPTH) begin w = 1; r = 1; end
      if (w && !r && q.size() == DEPTH) w = 0;
      if (w && (q.size() < DEPTH || r)) pushed++;
      if (q.size() == DEPTH) begin
        nxt = q[1];
        cycle(1, 1, 8'($urandom));
        n_chk++;
        if (full !== 1'b1 || rd_data !== nxt) begin
          n_fail++;
          $display("FAIL full_wr_rd: full=%b rd_data=%h, want 1 %h", full, rd_data, nxt);
        end
      end else begin
        cycle(w, r, 8'($urandom));
        n_chk++;
        if (rd_data !== exp_data() || empty !== 1'b0 || full !== (q.size() == DEPTH)) begin
          n_fail++;
          $display("FAIL wrap: rd_data=%h empty=%b full=%b, want %h 0 %b",
                   rd_data, empty, full, exp_data(), q.size() == DEPTH);
        end
      end
    end
    while (q.size() > 0) begin
      n_chk++;
      if (rd_data !== q[0]) begin
        n_fail++;
        $display("FAIL wrap_drain: rd_data=%h, want %h", rd_data, q[0]);
      end
      cycle(0, 1, 8'h00);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      cycle(1'($urandom), 1'($urandom), 8'($urandom));
      n_chk++;
      if (rd_data !== exp_data() || empty !== (q.size() == 0) || full !== (q.size() == DEPTH)) begin
        n_fail++;
        $display("FAIL random[%0d]: rd_data=%h empty=%b full=%b, want %h %b %b", i,
                 rd_data, empty, full, exp_data(), q.size() == 0, q.size() == DEPTH);
      end
    end
  endtask

  task automatic test_async_reset();
    while (q.size() > 0) cycle(0, 1, 8'h00);
    for (int i = 0; i < 5; i++) cycle(1, 0, 8'(8'h40 + i));
    cycle(0, 0, 8'h00);
    n_chk++;
    if (empty !== 1'b0 || rd_data !== 8'h40) begin
      n_fail++;
      $display("FAIL pre_reset: empty=%b rd_data=%h, want 0 40", empty, rd_data);
    end
    #2 reset = 0;
    #1;
    n_chk++;
    if (empty !== 1'b1 || full !== 1'b0 || rd_data !== 8'h00) begin
      n_fail++;
      $display("FAIL async_reset: empty=%b full=%b rd_data=%h, want 1 0 00", empty, full, rd_data);
    end
    q.delete();
    wr = 1; rd = 1; wr_data = 8'hEE;
    @(posedge clk); #1;
    n_chk++;
    if (empty !== 1'b1 || rd_data !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_inflight: empty=%b rd_data=%h, want 1 00", empty, rd_data);
    end
    wr = 0; rd = 0;
    #2 reset = 1;
    @(posedge clk); #1;
    cycle(1, 0, 8'hA7);
    n_chk++;
    if (empty !== 1'b0 || rd_data !== 8'hA7) begin
      n_fail++;
      $display("FAIL post_reset_head: empty=%b rd_data=%h, want 0 a7", empty, rd_data);
    end
    cycle(0, 1, 8'h00);
    n_chk++;
    if (empty !== 1'b1) begin
      n_fail++;
      $display("FAIL post_reset_pop: empty=%b, want 1", empty);
    end
  endtask

  initial begin
    test_reset();
    test_push_pop();
    test_fill();
    test_interleave();
    test_wrap();
    test_random();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
